// File: rtl/iob_cache_port_arbiter.sv
// iob_cache_port_arbiter
// Lets N_PORTS IOb-native masters share one iob_cache front-end port.
// A winner is picked per transaction (fixed priority or round-robin).
// The grant is held until the cache acks, and the ack is routed to the
// winning master only. On the ack cycle a new winner is picked among the
// other requesters, so back-to-back transactions have no idle cycle
// between them. Invalidate requests are OR-merged. The write-through-
// buffer empty status is fanned out to every port.
module iob_cache_port_arbiter #(
    parameter int N_PORTS  = 2,
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    // master side
    input  logic [N_PORTS-1:0]                              req_i,
    input  logic [N_PORTS*ADDR_W-1:0]                       addr_i,
    input  logic [N_PORTS*DATA_W-1:0]                       wdata_i,
    input  logic [N_PORTS*(DATA_W/8)-1:0]                   wstrb_i,
    output logic [N_PORTS*DATA_W-1:0]                       rdata_o,
    output logic [N_PORTS-1:0]                              ack_o,
    input  logic [N_PORTS-1:0]                              invalidate_i,
    output logic [N_PORTS-1:0]                              wtb_empty_o,
    // cache side
    output logic                                            c_req_o,
    output logic [ADDR_W-1:0]                               c_addr_o,
    output logic [DATA_W-1:0]                               c_wdata_o,
    output logic [DATA_W/8-1:0]                             c_wstrb_o,
    input  logic [DATA_W-1:0]                               c_rdata_i,
    input  logic                                            c_ack_i,
    output logic                                            c_invalidate_o,
    input  logic                                            c_wtb_empty_i,
    // status
    output logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] grant_o,
    output logic                                            busy_o
);

    localparam int GNT_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [GNT_W-1:0]   grant_q, grant_d;
    logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [N_PORTS-1:0] gnt_oh;
    logic [N_PORTS-1:0] arb_req;
    logic               win_vld;
    logic [GNT_W-1:0]   win_idx;

    // One-hot decode of the current grant, used for ack routing and masking
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned (that would infer a latch).
        gnt_oh = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            gnt_oh[k] = (grant_q == GNT_W'(k));
        end
    end

    // Winner search: port 0 first, or upward from rr_ptr+1 in round-robin mode.
    // While busy the current owner is masked, because it drops req after its ack.
    always_comb begin
        arb_req = req_i;
        if (state_q == BUSY) begin
            arb_req = req_i & ~gnt_oh;
        end
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            int idx;
            idx = (ARB_MODE == 0) ? i : ((int'(rr_ptr_q) + 1 + i) % N_PORTS);
            if (!win_vld && arb_req[idx]) begin
                win_vld = 1'b1;
                win_idx = GNT_W'(idx);
            end
        end
    end

    // Next-state logic for the IDLE/BUSY controller
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                // a stray c_ack_i here is ignored on purpose
                if (win_vld) begin
                    state_d  = BUSY;
                    grant_d  = win_idx;
                    rr_ptr_d = win_idx;
                end
            end
            BUSY: begin
                if (c_ack_i) begin
                    if (win_vld) begin
                        grant_d  = win_idx;
                        rr_ptr_d = win_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, grant and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GNT_W'(N_PORTS - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its inputs.
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Steer the granted port's payload to the cache and route its ack back
    always_comb begin
        c_addr_o  = '0;
        c_wdata_o = '0;
        c_wstrb_o = '0;
        ack_o     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (gnt_oh[k]) begin
                c_addr_o  = addr_i[k*ADDR_W +: ADDR_W];
                c_wdata_o = wdata_i[k*DATA_W +: DATA_W];
                c_wstrb_o = wstrb_i[k*STRB_W +: STRB_W];
            end
            ack_o[k] = (state_q == BUSY) && c_ack_i && gnt_oh[k];
        end
    end

    // Status and request come straight from flops. There is no path from req_i.
    assign busy_o  = (state_q == BUSY);
    assign c_req_o = (state_q == BUSY);
    assign grant_o = grant_q;

    // Broadcasts. Each master qualifies rdata with its own ack bit.
    assign rdata_o        = {N_PORTS{c_rdata_i}};
    assign wtb_empty_o    = {N_PORTS{c_wtb_empty_i}};
    assign c_invalidate_o = |invalidate_i;

endmodule

// File: tb/tb_iob_cache_port_arbiter.sv
// Directed bench for iob_cache_port_arbiter.
// Instance u_fp: 2 ports with fixed priority.
// Instance u_rr: 4 ports with round-robin.
module tb_iob_cache_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total      = 0;
    int bad        = 0;
    int proto_viol = 0;

    // ---------------- u_fp (N_PORTS=2, ARB_MODE=0) ----------------
    logic [1:0]  a_req, a_ack, a_inv, a_wtb;
    logic [59:0] a_addr;
    logic [63:0] a_wdata, a_rdata;
    logic [7:0]  a_wstrb;
    logic        a_creq, a_cinv, a_cack, a_cwtb, a_busy;
    logic [29:0] a_caddr;
    logic [31:0] a_cwdata, a_crdata;
    logic [3:0]  a_cwstrb;
    logic [0:0]  a_grant;

    // ---------------- u_rr (N_PORTS=4, ARB_MODE=1) ----------------
    logic [3:0]   b_req, b_ack, b_inv, b_wtb;
    logic [119:0] b_addr;
    logic [127:0] b_wdata, b_rdata;
    logic [15:0]  b_wstrb;
    logic         b_creq, b_cinv, b_cack, b_cwtb, b_busy;
    logic [29:0]  b_caddr;
    logic [31:0]  b_cwdata, b_crdata;
    logic [3:0]   b_cwstrb;
    logic [1:0]   b_grant;

    iob_cache_port_arbiter #(.N_PORTS(2), .ADDR_W(30), .DATA_W(32), .ARB_MODE(0)) u_fp (
        .clk_i(clk), .rst_i(rst_n),
        .req_i(a_req), .addr_i(a_addr), .wdata_i(a_wdata), .wstrb_i(a_wstrb),
        .rdata_o(a_rdata), .ack_o(a_ack), .invalidate_i(a_inv), .wtb_empty_o(a_wtb),
        .c_req_o(a_creq), .c_addr_o(a_caddr), .c_wdata_o(a_cwdata), .c_wstrb_o(a_cwstrb),
        .c_rdata_i(a_crdata), .c_ack_i(a_cack), .c_invalidate_o(a_cinv),
        .c_wtb_empty_i(a_cwtb), .grant_o(a_grant), .busy_o(a_busy)
    );

    iob_cache_port_arbiter #(.N_PORTS(4), .ADDR_W(30), .DATA_W(32), .ARB_MODE(1)) u_rr (
        .clk_i(clk), .rst_i(rst_n),
        .req_i(b_req), .addr_i(b_addr), .wdata_i(b_wdata), .wstrb_i(b_wstrb),
        .rdata_o(b_rdata), .ack_o(b_ack), .invalidate_i(b_inv), .wtb_empty_o(b_wtb),
        .c_req_o(b_creq), .c_addr_o(b_caddr), .c_wdata_o(b_cwdata), .c_wstrb_o(b_cwstrb),
        .c_rdata_i(b_crdata), .c_ack_i(b_cack), .c_invalidate_o(b_cinv),
        .c_wtb_empty_i(b_cwtb), .grant_o(b_grant), .busy_o(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive just after the rising edge and sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // A granted master must keep req high until its ack.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_busy && !a_req[a_grant]) proto_viol++;
            if (b_busy && !b_req[b_grant]) proto_viol++;
        end
    end

    initial begin
        a_req = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0; a_inv = '0;
        a_crdata = '0; a_cack = 1'b0; a_cwtb = 1'b1;
        b_req = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0; b_inv = '0;
        b_crdata = '0; b_cack = 1'b0; b_cwtb = 1'b1;

        // reset state
        #3;
        check("rst_a_creq",  a_creq,  1'b0);
        check("rst_a_busy",  a_busy,  1'b0);
        check("rst_a_grant", a_grant, 1'b0);
        check("rst_a_ack",   a_ack,   2'b00);
        check("rst_b_grant", b_grant, 2'd0);
        check("rst_b_cinv",  b_cinv,  1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- single port read on u_fp ----
        tick(); a_req = 2'b10; a_addr[30 +: 30] = 30'h10; smp();
        check("sp_no_comb_req", a_creq, 1'b0);
        tick(); smp();
        check("sp_creq",  a_creq,  1'b1);
        check("sp_addr",  a_caddr, 30'h10);
        check("sp_grant", a_grant, 1'b1);
        check("sp_busy",  a_busy,  1'b1);
        check("sp_ack_early", a_ack, 2'b00);
        tick(); smp(); check("sp_wait1_ack", a_ack, 2'b00);
        tick(); smp(); check("sp_wait2_ack", a_ack, 2'b00);
        tick(); a_cack = 1'b1; a_crdata = 32'hDEADBEEF; smp();
        check("sp_ack",    a_ack,           2'b10);
        check("sp_rdata1", a_rdata[63:32], 32'hDEADBEEF);
        check("sp_rdata0", a_rdata[31:0],  32'hDEADBEEF);
        tick(); a_cack = 1'b0; a_req = 2'b00; smp();
        check("sp_idle", a_busy, 1'b0);
        check("sp_ack_gone", a_ack, 2'b00);

        // ---- fixed priority on u_fp ----
        tick(); a_req = 2'b11; a_addr = {30'h200, 30'h100}; smp();
        check("fp_lat", a_creq, 1'b0);
        tick(); smp();
        check("fp_g0",    a_grant, 1'b0);
        check("fp_creq1", a_creq,  1'b1);
        check("fp_addr0", a_caddr, 30'h100);
        tick(); a_cack = 1'b1; smp();
        check("fp_ack0",  a_ack,  2'b01);
        check("fp_creq2", a_creq, 1'b1);
        tick(); a_cack = 1'b0; a_req = 2'b10; smp();
        check("fp_g1",    a_grant, 1'b1);
        check("fp_creq3", a_creq,  1'b1);
        check("fp_addr1", a_caddr, 30'h200);
        check("fp_noack", a_ack,   2'b00);
        tick(); a_cack = 1'b1; smp();
        check("fp_ack1",  a_ack,  2'b10);
        check("fp_creq4", a_creq, 1'b1);
        tick(); a_cack = 1'b0; a_req = 2'b00; smp();
        check("fp_idle", a_busy, 1'b0);

        // ---- round-robin on u_rr: cache acks every cycle ----
        for (int k = 0; k < 4; k++) b_addr[k*30 +: 30] = 30'h40 + 30'(k);
        tick(); b_req = 4'hF; smp();
        check("rr_lat", b_creq, 1'b0);
        for (int t = 0; t < 8; t++) begin
            tick(); b_cack = 1'b1;
            if (t == 7) b_req = 4'b1000;
            smp();
            check($sformatf("rr_grant%0d", t), b_grant, 64'(t % 4));
            check($sformatf("rr_ack%0d", t),   b_ack,   64'(1 << (t % 4)));
            check($sformatf("rr_addr%0d", t),  b_caddr, 64'(30'h40 + 30'(t % 4)));
            check($sformatf("rr_creq%0d", t),  b_creq,  1'b1);
        end
        tick(); b_cack = 1'b0; b_req = 4'b0000; smp();
        check("rr_idle", b_busy, 1'b0);

        // ---- write payload on u_rr ----
        b_addr[60 +: 30]  = 30'h22; b_wdata[64 +: 32] = 32'hA5A5A5A5; b_wstrb[8 +: 4]  = 4'b0011;
        b_addr[90 +: 30]  = 30'h33; b_wdata[96 +: 32] = 32'h0BADF00D; b_wstrb[12 +: 4] = 4'b0000;
        tick(); b_req = 4'b1100; smp();
        tick(); smp();
        check("wr_g2",    b_grant,  2'd2);
        check("wr_wdata", b_cwdata, 32'hA5A5A5A5);
        check("wr_wstrb", b_cwstrb, 4'b0011);
        check("wr_addr",  b_caddr,  30'h22);
        tick(); smp();
        check("wr_hold_wdata", b_cwdata, 32'hA5A5A5A5);
        tick(); b_cack = 1'b1; smp();
        check("wr_ack2",      b_ack,    4'b0100);
        check("wr_ack_wdata", b_cwdata, 32'hA5A5A5A5);
        check("wr_ack_wstrb", b_cwstrb, 4'b0011);
        tick(); b_cack = 1'b0; b_req = 4'b1000; smp();
        check("wr_g3",     b_grant,  2'd3);
        check("wr_wstrb3", b_cwstrb, 4'b0000);
        check("wr_wdata3", b_cwdata, 32'h0BADF00D);
        check("wr_addr3",  b_caddr,  30'h33);
        tick(); b_cack = 1'b1; smp();
        check("wr_ack3", b_ack, 4'b1000);
        tick(); b_cack = 1'b0; b_req = 4'b0000; smp();
        check("wr_idle", b_busy, 1'b0);

        // ---- invalidate and wtb_empty on u_rr ----
        b_addr[0 +: 30] = 30'h5;
        tick(); b_req = 4'b0001; smp();
        check("inv_quiet", b_cinv, 1'b0);
        tick(); b_inv = 4'b0010; smp();
        check("inv_pulse", b_cinv,  1'b1);
        check("inv_busy",  b_busy,  1'b1);
        check("inv_grant", b_grant, 2'd0);
        tick(); b_inv = 4'b0000; b_cwtb = 1'b0; smp();
        check("inv_drop", b_cinv, 1'b0);
        check("wtb_c1",   b_wtb,  4'h0);
        tick(); b_cack = 1'b1; b_inv = 4'b1000; smp();
        check("inv_ack",      b_ack,  4'b0001);
        check("inv_with_ack", b_cinv, 1'b1);
        check("wtb_c2",       b_wtb,  4'h0);
        tick(); b_cack = 1'b0; b_inv = 4'b0000; b_req = 4'b0000; smp();
        check("inv_idle", b_busy, 1'b0);
        check("wtb_c3",   b_wtb,  4'h0);
        tick(); smp(); check("wtb_c4", b_wtb, 4'h0);
        tick(); smp(); check("wtb_c5", b_wtb, 4'h0);
        tick(); b_cwtb = 1'b1; smp();
        check("wtb_back", b_wtb, 4'hF);

        // ---- reset mid-transaction, stray ack, restart ----
        tick(); a_req = 2'b01; a_addr[0 +: 30] = 30'h7; b_req = 4'b0010; smp();
        tick(); smp();
        check("mr_a_busy",  a_busy,  1'b1);
        check("mr_b_grant", b_grant, 2'd1);
        check("mr_b_busy",  b_busy,  1'b1);
        tick(); rst_n = 1'b0; a_req = 2'b00; b_req = 4'b0000; a_cack = 1'b1; b_cack = 1'b1;
        #1;
        check("mr_a_creq",  a_creq,  1'b0);
        check("mr_a_busy0", a_busy,  1'b0);
        check("mr_a_ack",   a_ack,   2'b00);
        check("mr_b_creq",  b_creq,  1'b0);
        check("mr_b_busy0", b_busy,  1'b0);
        check("mr_b_grant0", b_grant, 2'd0);
        check("mr_b_ack",   b_ack,   4'b0000);
        tick(); tick(); rst_n = 1'b1; smp();
        check("stray_a_ack",  a_ack,  2'b00);
        check("stray_b_ack",  b_ack,  4'b0000);
        check("stray_a_busy", a_busy, 1'b0);
        check("stray_b_busy", b_busy, 1'b0);
        tick(); smp();
        check("stray2_b_ack",  b_ack,  4'b0000);
        check("stray2_b_busy", b_busy, 1'b0);
        tick(); a_cack = 1'b0; b_cack = 1'b0; a_req = 2'b11; b_req = 4'hF; smp();
        tick(); smp();
        check("post_a_grant", a_grant, 1'b0);
        check("post_a_creq",  a_creq,  1'b1);
        check("post_b_grant", b_grant, 2'd0);
        check("post_b_creq",  b_creq,  1'b1);

        check("protocol", 64'(proto_viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_cache_port_arbiter.md
Name: iob_cache_port_arbiter

Overview:
- N-port front-end arbiter that lets several IOb-native masters (e.g. CPU instruction bus, data bus, DMA) share one iob_cache front-end port.
- Sits between the masters and the cache's req/addr/wdata/wstrb/rdata/ack interface.
- Selects one master per transaction (fixed-priority or round-robin), holds the grant until the cache acks, and returns the ack to that master only.
- Merges per-port invalidate requests and fans the write-through-buffer empty status out to all ports.

Parameters:
- N_PORTS, 2, number of master ports; 2 to 16.
- ADDR_W, 30, word-address width per port, including the ctrl-select MSB when the cache uses it.
- DATA_W, 32, data width; a multiple of 8.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (port 0 highest), 1 = round-robin.
- GNT_W, $clog2(N_PORTS) (minimum 1), width of the grant index; derived, not overridable.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-low.
- req_i  in  N_PORTS  per-port request; held high with stable payload until that port's ack.
- addr_i  in  N_PORTS*ADDR_W  per-port word address; port k occupies bits [k*ADDR_W +: ADDR_W].
- wdata_i  in  N_PORTS*DATA_W  per-port write data.
- wstrb_i  in  N_PORTS*DATA_W/8  per-port byte strobes; all zero means read.
- rdata_o  out  N_PORTS*DATA_W  per-port read data; every slice carries c_rdata_i.
- ack_o  out  N_PORTS  per-port one-cycle ack.
- invalidate_i  in  N_PORTS  per-port invalidate request pulse.
- wtb_empty_o  out  N_PORTS  per-port copy of c_wtb_empty_i.
- c_req_o  out  1  request to the cache.
- c_addr_o  out  ADDR_W  address of the granted port.
- c_wdata_o  out  DATA_W  write data of the granted port.
- c_wstrb_o  out  DATA_W/8  byte strobes of the granted port.
- c_rdata_i  in  DATA_W  cache read data.
- c_ack_i  in  1  cache ack, one cycle.
- c_invalidate_o  out  1  invalidate to the cache (feeds invalidate_in).
- c_wtb_empty_i  in  1  cache write-through buffer empty (from wtb_empty_out).
- grant_o  out  GNT_W  index of the currently granted port.
- busy_o  out  1  a transaction is outstanding.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, grant_q = 0, rr_ptr = N_PORTS-1 (so port 0 wins first).
  - ack_o = 0, c_req_o = 0, busy_o = 0, grant_o = 0, c_invalidate_o = 0.
- FSM states: IDLE and BUSY.
  - busy_o = (state == BUSY).
  - c_req_o = busy_o, registered: no combinational path from req_i to c_req_o.
  - c_addr_o, c_wdata_o and c_wstrb_o are muxed from grant_q.
- IDLE:
  - When any req_i bit is set, latch the winner into grant_q and go to BUSY next cycle.
  - Latency from req_i rising to c_req_o rising is 1 cycle.
- Winner selection:
  - ARB_MODE=0: lowest-index requesting port.
  - ARB_MODE=1: first requesting port scanning upward from rr_ptr+1, modulo N_PORTS. rr_ptr is loaded with the winner on every grant.
- BUSY:
  - Hold grant_q and c_req_o until c_ack_i.
  - In the c_ack_i cycle, ack_o[grant_q] = 1 combinationally from c_ack_i; all other ack_o bits stay 0.
- Back-to-back:
  - In the c_ack_i cycle, re-arbitrate among req_i with the bit for grant_q masked off. That port drops req after its ack.
  - If a winner exists, stay in BUSY with the new grant_q from the next cycle: zero idle cycles between transactions.
  - Otherwise go to IDLE.
- c_req_o stays high across a back-to-back switch. The cache samples a new request on every cycle following an ack.
- A granted port dropping req_i before its ack is a protocol violation. The arbiter holds the grant regardless; a bench assertion flags it.
- rdata_o is a combinational broadcast of c_rdata_i. Masters qualify it with their own ack_o bit only.
- c_invalidate_o = |invalidate_i (combinational), independent of arbitration state.
- wtb_empty_o[k] = c_wtb_empty_i for every k.
- Simultaneous c_ack_i and invalidate_i: both are honoured; the ack routes normally.
- A c_ack_i arriving in IDLE is ignored: no ack_o pulse, no state change.
- Reset asserted mid-transaction abandons it; no ack_o is produced after reset deassertion.

Test Plan:
- Single port:
  - Stimulus: N_PORTS=2, port1 reads addr 0x10; cache acks 3 cycles after c_req_o with rdata 0xDEADBEEF.
  - Required: c_req_o rises 1 cycle after req_i[1], c_addr_o=0x10, grant_o=1, ack_o=2'b10 in the ack cycle, rdata_o[63:32]=0xDEADBEEF.
- Fixed priority:
  - Stimulus: ARB_MODE=0; ports 0 and 1 request in the same cycle; cache acks each after 1 cycle.
  - Required: port 0 served first. Port 1 is granted in the cycle after port 0's ack, c_req_o never drops, 2 acks in 4 cycles.
- Round-robin:
  - Stimulus: ARB_MODE=1, N_PORTS=4, all ports re-request continuously for 8 transactions.
  - Required: grant sequence 0,1,2,3,0,1,2,3; no port waits more than 3 transactions.
- Write payload:
  - Stimulus: port 2 writes wdata 0xA5A5A5A5, wstrb 4'b0011 while port 3 requests a read.
  - Required: c_wdata_o=0xA5A5A5A5 and c_wstrb_o=4'b0011 while grant_o=2; they switch to port 3's values only after port 2's ack.
- Invalidate and wtb_empty:
  - Stimulus: pulse invalidate_i[1] during a BUSY transaction; drive c_wtb_empty_i low for 5 cycles.
  - Required: c_invalidate_o pulses the same cycle, the transaction completes unaffected, and wtb_empty_o = all zeros for exactly those 5 cycles.
- Reset mid-transaction:
  - Stimulus: assert rst_i low while BUSY, then release; apply a stray c_ack_i in IDLE.
  - Required: c_req_o, ack_o, busy_o, grant_o are 0 immediately on reset assertion. The stray ack produces no ack_o. The next request is granted to port 0 in both modes.
